// File: rtl/pk_detector.sv
// Peak detector: arms at a threshold, follows the running maximum, and confirms a peak
// once the input drops HYST below it. Define PK_DETECTOR_COUNT_EN to add the pk_count port.
module pk_detector #(
    parameter int DATA_W      = 12,
    parameter int HYST        = 16,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] threshold,
    input  logic              clear,
    output logic              pk_detect,
    output logic [DATA_W-1:0] pk_value
`ifdef PK_DETECTOR_COUNT_EN
    ,
    output logic [15:0]       pk_count
`endif
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [DATA_W:0]   HYST_V    = (DATA_W+1)'(HYST);

    typedef enum logic [1:0] {ARMED, TRACK, HOLD, REARM} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] pk_value_q;
    logic              pk_detect_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              below_seen_q;

    logic              below;
    logic              above_max;
    logic [DATA_W:0]   drop;

    assign below     = sample_data < threshold;
    assign above_max = sample_data > max_q;
    // Only consulted when the sample is at or below max, so it never wraps.
    assign drop      = {1'b0, max_q} - {1'b0, sample_data};

`ifdef PK_DETECTOR_COUNT_EN
    logic [15:0] pk_count_q;
    assign pk_count = pk_count_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARMED;
            max_q        <= '0;
            pk_value_q   <= '0;
            pk_detect_q  <= 1'b0;
            cnt_q        <= '0;
            below_seen_q <= 1'b0;
`ifdef PK_DETECTOR_COUNT_EN
            pk_count_q   <= '0;
`endif
        end else if (clear) begin
            state_q      <= ARMED;
            pk_detect_q  <= 1'b0;
            cnt_q        <= '0;
            below_seen_q <= 1'b0;
`ifdef PK_DETECTOR_COUNT_EN
            pk_count_q   <= '0;
`endif
        end else begin
            case (state_q)
                ARMED: begin
                    if (sample_valid && !below) begin
                        state_q <= TRACK;
                        max_q   <= sample_data;
                    end
                end
                TRACK: begin
                    if (sample_valid) begin
                        if (above_max) begin
                            max_q <= sample_data;
                        end else if (drop >= HYST_V) begin
                            pk_value_q  <= max_q;
                            pk_detect_q <= 1'b1;
                            cnt_q       <= HOLD_LOAD;
                            state_q     <= HOLD;
`ifdef PK_DETECTOR_COUNT_EN
                            if (pk_count_q != 16'hFFFF) pk_count_q <= pk_count_q + 16'd1;
`endif
                        end else if (below) begin
                            state_q <= ARMED;
                        end
                    end
                end
                HOLD: begin
                    if (sample_valid && below) below_seen_q <= 1'b1;
                    if (cnt_q == '0) begin
                        // A low sample on the exit cycle itself also counts as seen.
                        pk_detect_q  <= 1'b0;
                        below_seen_q <= 1'b0;
                        state_q      <= (below_seen_q || (sample_valid && below)) ? ARMED : REARM;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                REARM: begin
                    if (sample_valid && below) state_q <= ARMED;
                end
                default: state_q <= ARMED;
            endcase
        end
    end

    assign pk_detect = pk_detect_q;
    assign pk_value  = pk_value_q;

endmodule

// File: tb/tb_pk_detector.sv
// Directed bench for pk_detector (threshold 150, HYST 16, HOLD_CYCLES 8).
module tb_pk_detector;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic [11:0] threshold;
    logic        clear;
    logic        pk_detect;
    logic [11:0] pk_value;
`ifdef PK_DETECTOR_COUNT_EN
    logic [15:0] pk_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    pk_detector #(.DATA_W(12), .HYST(16), .HOLD_CYCLES(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .threshold    (threshold),
        .clear        (clear),
        .pk_detect    (pk_detect),
        .pk_value     (pk_value)
`ifdef PK_DETECTOR_COUNT_EN
        ,
        .pk_count     (pk_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, land on the following falling edge.
    task automatic step(input logic v, input logic [11:0] d);
        sample_valid = v;
        sample_data  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 12'd0);
    endtask

    initial begin
        reset_n = 1'b0; sample_valid = 1'b0; sample_data = '0;
        threshold = 12'd150; clear = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset_pk_detect", 32'(pk_detect), 0);
        chk("reset_pk_value", 32'(pk_value), 0);
`ifdef PK_DETECTOR_COUNT_EN
        chk("reset_pk_count", 32'(pk_count), 0);
`endif
        reset_n = 1'b1;

        // Rise to 300, small dip of 10 is not a peak, drop of 30 is.
        step(1, 100); step(1, 200); step(1, 300); step(1, 290);
        chk("dip10_no_peak", 32'(pk_detect), 0);
        step(1, 270);
        chk("peak300_detect", 32'(pk_detect), 1);
        chk("peak300_value", 32'(pk_value), 300);

        // Held for exactly 8 cycles in total.
        for (int i = 0; i < 7; i++) begin
            idle(1);
            chk("hold_high", 32'(pk_detect), 1);
        end
        idle(1);
        chk("hold_end_low", 32'(pk_detect), 0);

        // REARM: high samples do not re-arm until one goes below threshold.
        step(1, 400); step(1, 350);
        chk("rearm_no_peak", 32'(pk_detect), 0);
        step(1, 100);
        chk("rearm_below_no_peak", 32'(pk_detect), 0);
        step(1, 400); step(1, 350);
        chk("peak400_detect", 32'(pk_detect), 1);
        chk("peak400_value", 32'(pk_value), 400);

        // Low sample during HOLD sends it straight to ARMED on exit.
        step(1, 100); idle(6);
        chk("hold2_still_high", 32'(pk_detect), 1);
        idle(1);
        chk("hold2_end_low", 32'(pk_detect), 0);

        // Noise rejection, then rearm at 200 with HYST boundary 15 vs 16.
        step(1, 160); step(1, 155); step(1, 145);
        chk("noise_no_peak", 32'(pk_detect), 0);
        step(1, 200); step(1, 185);
        chk("drop15_no_peak", 32'(pk_detect), 0);
        step(1, 184);
        chk("drop16_peak", 32'(pk_detect), 1);
        chk("peak200_value", 32'(pk_value), 200);

        // Async reset 3 cycles into HOLD, checked before the next rising edge.
        idle(2);
        reset_n = 1'b0;
        #1;
        chk("async_rst_detect", 32'(pk_detect), 0);
        chk("async_rst_value", 32'(pk_value), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 200); step(1, 180);
        chk("post_rst_peak", 32'(pk_detect), 1);
        chk("post_rst_value", 32'(pk_value), 200);

        // Clear mid-HOLD: flag drops on the next edge, value kept, back to ARMED.
        idle(2);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clear_detect", 32'(pk_detect), 0);
        chk("clear_value_kept", 32'(pk_value), 200);
        step(1, 250); step(1, 230);
        chk("post_clear_peak", 32'(pk_detect), 1);
        chk("post_clear_value", 32'(pk_value), 250);

        // Two more peaks (REARM exit via a low sample each time).
        idle(8);
        step(1, 100); step(1, 300); step(1, 280);
        chk("peak_b_value", 32'(pk_value), 300);
        idle(8);
        step(1, 100); step(1, 320); step(1, 300);
        chk("peak_c_value", 32'(pk_value), 320);
`ifdef PK_DETECTOR_COUNT_EN
        chk("count_three", 32'(pk_count), 3);
        idle(8);
        step(1, 100); step(1, 330);
        force dut.pk_count_q = 16'hFFFF;
        #1;
        release dut.pk_count_q;
        step(1, 310);
        chk("count_saturate", 32'(pk_count), 32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pk_detector.md
PK_DETECTOR -- requirements
Module: pk_detector

Interface
REQ-001 The block SHALL be configured by parameters (name, default, meaning):
- DATA_W, 12: sample and threshold width, unsigned.
- HYST, 16: minimum drop below the running maximum that confirms a peak.
- HOLD_CYCLES, 1024: clock cycles pk_detect is held high; legal range is 1 or more.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all logic on its rising edge.
- reset_n, in, 1: reset, asynchronous and active-low.
- sample_valid, in, 1: sample_data is valid this cycle.
- sample_data, in, DATA_W: unsigned input sample.
- threshold, in, DATA_W: arming level, sampled live on every valid sample.
- clear, in, 1: synchronous soft clear.
- pk_detect, out, 1: registered peak flag; this is the level sampled by the downstream PIO input.
- pk_value, out, DATA_W: registered value of the last confirmed peak.
- pk_count, out, 16: confirmed-peak count; present only under REQ-016.

Function
REQ-003 The state machine SHALL have four states: ARMED, TRACK, HOLD, REARM.

REQ-004 In ARMED, a valid sample at or above threshold SHALL move the state to TRACK and load the running max with that sample; samples below threshold SHALL change nothing.

REQ-005 In TRACK, each valid sample SHALL be handled in this priority order:
- sample greater than max: max is updated to the sample.
- (max - sample) at or above HYST: peak is confirmed.
- sample below threshold: state returns to ARMED with no peak (noise rejection).

REQ-006 The subtraction (max - sample) SHALL be computed in DATA_W+1 bits and evaluated only when sample is at or below max, so no underflow occurs.

REQ-007 Peak confirmation SHALL occur as follows:
- pk_value is loaded with max on the same edge as the confirming sample.
- pk_detect goes to 1 on that edge, so it is visible the cycle after the confirming sample (latency of 1).
- The hold counter is loaded with HOLD_CYCLES-1 and the state moves to HOLD.

REQ-008 In HOLD, the following SHALL apply:
- pk_detect stays at 1.
- The counter decrements every clk cycle, independent of sample_valid.
- Samples never trigger a new peak.
- A below_seen flag is set by any valid sample below threshold.

REQ-009 When the HOLD counter is 0, the next edge SHALL clear pk_detect, so pk_detect is high for exactly HOLD_CYCLES cycles. The next state SHALL be ARMED if below_seen is set, otherwise REARM; below_seen SHALL clear on HOLD exit.

REQ-010 In REARM, the first valid sample below threshold SHALL move the state to ARMED; that sample SHALL NOT itself arm TRACK.

REQ-011 With sample_valid low, state, max, and pk_value SHALL hold; only the HOLD counter advances.

REQ-012 clear SHALL take priority over all other inputs: state goes to ARMED, pk_detect to 0, the counter and below_seen to 0, and pk_count to 0. pk_value SHALL be retained.

REQ-013 A change of threshold while in TRACK, HOLD, or REARM SHALL take effect on the next valid sample.

Reset
REQ-014 On reset_n low, all state SHALL clear asynchronously: state goes to ARMED, and pk_detect, pk_value, max, the counter, below_seen, and pk_count go to 0.

REQ-015 Asserting reset_n mid-HOLD SHALL drop pk_detect without waiting for a clock edge. After reset_n deasserts, the first active edge SHALL behave as ARMED.

Configuration
REQ-016 Macro PK_DETECTOR_COUNT_EN SHALL control the peak counter:
- Defined: pk_count exists and increments by 1 on each confirmed peak. It saturates at 0xFFFF and is cleared by clear and by reset.
- Undefined: the pk_count port and all counter logic are absent; all other behaviour is identical.

Verification
REQ-017 The bench SHALL cover these directed scenarios (threshold=150, HYST=16, HOLD_CYCLES=8 unless stated):
- Samples 100, 200, 300, 290, 270 -> no peak at 290 (drop 10); pk_detect=1 the cycle after 270; pk_value=300.
- Peak confirmed, samples idle -> pk_detect high for exactly 8 cycles, then 0; state is REARM.
- After the HOLD above, samples 400, 350 with none below 150 -> no second pk_detect; then samples 100, 400, 350 -> pk_detect=1, pk_value=400.
- Samples 160, 155, 145 -> pk_detect stays 0; the next sample 200 re-enters TRACK with max=200.
- reset_n low 3 cycles into HOLD -> pk_detect=0 and pk_value=0 immediately, asynchronously; clear mid-HOLD -> pk_detect=0 next edge, pk_value retained.
- PK_DETECTOR_COUNT_EN defined, three distinct peaks -> pk_count=3; forced to 0xFFFF plus one peak -> remains 0xFFFF.
